// File: rtl/uarch_rst_sequencer.sv
// uarch_rst_sequencer: walks a microarchitectural reset across NUM_DOMAINS
// stateful units. It flushes each domain in turn, waits for the memory side
// to drain, and then holds every domain reset for RST_CYCLES.
//
// Optional feature: define UARCH_RST_TIMEOUT_EN to bound each flush wait to
// TIMEOUT_CYCLES. When a domain misses that bound, the sequencer advances
// anyway and raises the sticky timeout_o. Without the macro, a flush waits
// indefinitely and timeout_o is tied low.
//
// Flush handshake: flush_req_o[idx] is a level and stays high until the
// sequencer samples flush_ack_i[idx]=1 on a rising clk_i edge. The next cycle
// moves the request to idx+1, or drops it after the last domain. Ack bits for
// other domains are never sampled.
//
// The state is visible on the internal state_q (state_e). Every output is a
// flop computed from the next-state decode, so no input reaches an output
// combinationally.
module uarch_rst_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int DRAIN_CYCLES   = 16,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic [NUM_DOMAINS-1:0] flush_req_o,
  input  logic [NUM_DOMAINS-1:0] flush_ack_i,
  input  logic [NUM_DOMAINS-1:0] idle_i,
  output logic [NUM_DOMAINS-1:0] rst_domain_no,
  output logic                   stall_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   timeout_o
);

  localparam int CNT_MAX_DR = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_DR > TIMEOUT_CYCLES) ? CNT_MAX_DR : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int IDX_W      = $clog2(NUM_DOMAINS);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
`ifdef UARCH_RST_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESET = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] flush_req_q, flush_req_d;
  logic [NUM_DOMAINS-1:0] rst_dom_n_q, rst_dom_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   step;
`ifdef UARCH_RST_TIMEOUT_EN
  logic                   timeout_q, timeout_d;
`endif

  // Next-state, counter and registered-output decode for the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    step    = 1'b0;
`ifdef UARCH_RST_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FLUSH;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef UARCH_RST_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      ST_FLUSH: begin
        step = flush_ack_i[idx_q];
`ifdef UARCH_RST_TIMEOUT_EN
        // A real ack wins over an expiring timer, leaving timeout_o alone.
        if (!flush_ack_i[idx_q]) begin
          if (cnt_q == TIMEOUT_LAST) begin
            step      = 1'b1;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`endif
        if (step) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      ST_DRAIN: begin
        // Any non-idle domain restarts the consecutive-idle count.
        if (&idle_i) begin
          if (cnt_q == DRAIN_LAST) begin
            state_d = ST_RESET;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    flush_req_d = '0;
    if (state_d == ST_FLUSH) begin
      flush_req_d[idx_d] = 1'b1;
    end
    rst_dom_n_d = (state_d == ST_RESET) ? '0 : '1;
    busy_d      = (state_d != ST_IDLE);
  end

  // State, counters and output registers; the async reset forces outputs to the idle values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      flush_req_q <= '0;
      rst_dom_n_q <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef UARCH_RST_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      flush_req_q <= flush_req_d;
      rst_dom_n_q <= rst_dom_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef UARCH_RST_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign flush_req_o   = flush_req_q;
  assign rst_domain_no = rst_dom_n_q;
  assign busy_o        = busy_q;
  assign stall_o       = busy_q;
  assign done_o        = done_q;
`ifdef UARCH_RST_TIMEOUT_EN
  assign timeout_o     = timeout_q;
`else
  assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_uarch_rst_sequencer.sv
// Bench for uarch_rst_sequencer. Expected request/reset/done events are
// derived from the start cycle and the programmed ack delays. They are queued
// when a sequence is launched and then popped as the monitor sees each event.
module tb_uarch_rst_sequencer;

  localparam int N     = 4;
  localparam int DRAIN = 16;
  localparam int RSTC  = 16;
  localparam int TO    = 8;
`ifdef UARCH_RST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] ack   = '0;
  logic [N-1:0] idle  = '1;
  logic [N-1:0] req;
  logic [N-1:0] rst_dom_n;
  logic         stall, busy, done, tmo;

  uarch_rst_sequencer #(
    .NUM_DOMAINS   (N),
    .DRAIN_CYCLES  (DRAIN),
    .RST_CYCLES    (RSTC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .flush_req_o  (req),
    .flush_ack_i  (ack),
    .idle_i       (idle),
    .rst_domain_no(rst_dom_n),
    .stall_o      (stall),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_o    (tmo)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  // exp_req_q : {req value[31:24], cycle[23:0]}
  // exp_rst_q : cycle where rst_domain_no first reads all 0
  // exp_done_q: {timeout_o expected[31], cycle[23:0]}
  logic [31:0] exp_req_q[$];
  logic [31:0] exp_rst_q[$];
  logic [31:0] exp_done_q[$];

  int ack_dly[N];
  bit spur_en = 1'b0;

  function automatic int eff_dly(input int d);
    if (TO_EN && d >= TO) return TO - 1;
    return d;
  endfunction

  function automatic int drain_start(input int s);
    int r = s + 1;
    for (int i = 0; i < N; i++) r = r + eff_dly(ack_dly[i]) + 1;
    return r;
  endfunction

  // Push all events for a sequence whose start is sampled in cycle s.
  // q_idle >= 0 is the cycle where idle_i returned to all 1 after a disturbance.
  task automatic expect_run(input int s, input int q_idle);
    int r = s + 1;
    bit t = 1'b0;
    int rs;
    for (int i = 0; i < N; i++) begin
      exp_req_q.push_back({8'(1 << i), 24'(r)});
      if (TO_EN && ack_dly[i] >= TO) t = 1'b1;
      r = r + eff_dly(ack_dly[i]) + 1;
    end
    rs = (q_idle >= 0) ? q_idle + DRAIN : r + DRAIN;
    exp_rst_q.push_back(32'(rs));
    exp_done_q.push_back({t, 7'd0, 24'(rs + RSTC)});
  endtask

  // ---------------- ack responder ----------------
  logic [N-1:0] resp_prev = '0;
  int           resp_age  = 0;
  always @(negedge clk) begin
    ack = '0;
    if (rst_n && req != '0) begin
      if (req == resp_prev) resp_age++;
      else resp_age = 0;
      for (int i = 0; i < N; i++)
        if (req[i] && resp_age == ack_dly[i]) ack[i] = 1'b1;
      if (spur_en) ack = ack | (N'($urandom_range(0, 15)) & ~req);
    end else begin
      resp_age = 0;
    end
    resp_prev = req;
  end

  // ---------------- monitor ----------------
  logic [N-1:0] req_prev  = '0;
  logic [N-1:0] rst_prev  = '1;
  logic         done_prev = 1'b0;
  int           rst_fall  = 0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      if (req != req_prev && req != '0) begin
        chk_val("req_onehot", $countones(req), 1);
        chk_val("req_busy", busy, 1);
        chk_val("stall_eq_busy", stall, busy);
        if (exp_req_q.size() == 0) chk_val("req_unexpected", 32'(req), 0);
        else begin
          e = exp_req_q.pop_front();
          chk_val("req_val", 32'(req), 32'(e[31:24]));
          chk_val("req_cyc", cyc, 32'(e[23:0]));
        end
      end
      if (rst_dom_n != rst_prev) begin
        if (rst_prev == '1) begin
          rst_fall = cyc;
          chk_val("rst_all_low", 32'(rst_dom_n), 0);
          if (exp_rst_q.size() == 0) chk_val("rst_unexpected", cyc, 0);
          else chk_val("rst_cyc", cyc, exp_rst_q.pop_front());
        end else if (rst_dom_n == '1) begin
          chk_val("rst_len", cyc - rst_fall, RSTC);
        end
      end
      if (done) begin
        chk_val("done_busy", busy, 0);
        if (exp_done_q.size() == 0) chk_val("done_unexpected", cyc, 0);
        else begin
          e = exp_done_q.pop_front();
          chk_val("done_cyc", cyc, 32'(e[23:0]));
          chk_val("done_tmo", tmo, e[31]);
        end
      end
      if (done_prev) chk_val("done_width", done, 0);
    end
    req_prev  = req;
    rst_prev  = rst_dom_n;
    done_prev = done & rst_n;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int lim = cyc + budget;
    while (exp_done_q.size() != 0 && cyc < lim) @(negedge clk);
    if (exp_done_q.size() != 0) begin
      chk_val("done_wait_expired", 0, 1);
      exp_req_q.delete();
      exp_rst_q.delete();
      exp_done_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic launch(input int q_idle);
    int s = cyc;
    start = 1'b1;
    expect_run(s, q_idle);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk_val({tag, "_req"}, 32'(req), 0);
    chk_val({tag, "_rst"}, 32'(rst_dom_n), 32'({N{1'b1}}));
    chk_val({tag, "_busy"}, busy, 0);
    chk_val({tag, "_stall"}, stall, 0);
    chk_val({tag, "_done"}, done, 0);
    chk_val({tag, "_tmo"}, tmo, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s, d0;
    for (int i = 0; i < N; i++) ack_dly[i] = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: immediate acks, always idle
    launch(-1);
    wait_done(200);

    // 2: domain 2 acks 10 cycles late, random noise on the other ack bits
    ack_dly[2] = 10;
    spur_en    = 1'b1;
    launch(-1);
    wait_done(200);
    spur_en    = 1'b0;
    ack_dly[2] = 0;

    // 3: idle_i[1] drops at drain count 9 for three cycles
    s  = cyc;
    d0 = drain_start(s);
    launch(d0 + 12);
    wait_cyc(d0 + 9);
    idle[1] = 1'b0;
    wait_cyc(d0 + 12);
    idle = '1;
    wait_done(200);

    // 4: start held high through the sequence, restart taken in the done cycle
    for (int i = 0; i < N; i++) ack_dly[i] = $urandom_range(0, 5);
    s = cyc;
    start = 1'b1;
    expect_run(s, -1);
    wait_cyc(drain_start(s) + DRAIN + RSTC);
    expect_run(cyc, -1);
    @(negedge clk);
    start = 1'b0;
    wait_done(400);
    wait_done(400);
    for (int i = 0; i < N; i++) ack_dly[i] = 0;

`ifdef UARCH_RST_TIMEOUT_EN
    // 5: domain 1 never acks, then acks on the last allowed cycle
    ack_dly[1] = 1000;
    launch(-1);
    wait_done(200);
    ack_dly[1] = TO - 1;
    launch(-1);
    wait_done(200);
    ack_dly[1] = 0;
`endif

    // 6: async reset while domain resets are held, then a full sequence
    s = cyc;
    launch(-1);
    wait_cyc(drain_start(s) + DRAIN + 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    exp_req_q.delete();
    exp_rst_q.delete();
    exp_done_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(-1);
    wait_done(200);

    chk_val("left_req", exp_req_q.size(), 0);
    chk_val("left_rst", exp_rst_q.size(), 0);
    chk_val("end_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uarch_rst_sequencer.md
# uarch_rst_sequencer

Sequences a full microarchitectural reset across `NUM_DOMAINS` stateful units (I$, D$, TLBs, branch predictor), one domain at a time:
- flush each domain in turn with a req/ack handshake;
- wait until every domain's memory interface has been idle for `DRAIN_CYCLES` consecutive cycles;
- hold all domain resets for `RST_CYCLES`;
- report completion.

It sits beside the flush controller, and `start_i` is driven by the fence.t path once padding expires.

## Interface
Parameters:
- `NUM_DOMAINS`, 4: number of sequenced domains (≥2).
- `DRAIN_CYCLES`, 16: required consecutive all-idle cycles (≥1).
- `RST_CYCLES`, 16: cycles reset is held (≥1).
- `TIMEOUT_CYCLES`, 1024: ack wait limit per domain (≥1; used only with the macro).

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  start request; sampled only in IDLE, ignored otherwise.
- `flush_req_o`  out  `NUM_DOMAINS`  level flush request; at most one bit high.
- `flush_ack_i`  in  `NUM_DOMAINS`  flush done, one-cycle pulse per domain.
- `idle_i`  in  `NUM_DOMAINS`  domain has no outstanding external transaction.
- `rst_domain_no`  out  `NUM_DOMAINS`  active-low domain reset.
- `stall_o`  out  1  block new memory requests; equals `busy_o`.
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `timeout_o`  out  1  sticky: some domain failed to ack.

## Operation
- States: IDLE, FLUSH, DRAIN, RESET.
- IDLE: `start_i`=1 → FLUSH with domain index = 0 and counter = 0; clear `timeout_o`.
- FLUSH:
  - `flush_req_o[idx]`=1 and all other bits 0.
  - `flush_ack_i[idx]` → if idx = `NUM_DOMAINS`-1, go to DRAIN with counter = 0; otherwise idx+1 and counter = 0.
  - Ack bits other than idx are ignored.
- DRAIN:
  - When `&idle_i` holds, counter +1; otherwise counter = 0.
  - Go to RESET when `&idle_i` holds and counter = `DRAIN_CYCLES`-1; counter = 0 on entry to RESET.
- RESET:
  - `rst_domain_no` = all 0.
  - Go to IDLE when counter = `RST_CYCLES`-1; otherwise counter +1.
- `done_o` is high in the first IDLE cycle after RESET. It is registered and set on the RESET→IDLE transition.
- A `start_i` in that same cycle is accepted.
- Counter width: `$clog2(max(DRAIN_CYCLES, RST_CYCLES, TIMEOUT_CYCLES)+1)`.
- Index width: `$clog2(NUM_DOMAINS)`.
- No wrap-around is possible: every compare exits before saturation.
- Illegal state encoding → IDLE.

## Timing
- All outputs decode from registers only; there is no input→output combinational path.
- Reset values: `flush_req_o`=0, `rst_domain_no`=all 1, `stall_o`=0, `busy_o`=0, `done_o`=0, `timeout_o`=0, state IDLE.
- Asserting `rst_ni` mid-sequence returns every output to these values immediately. Any request in flight is dropped.
- `start_i` at cycle 0 → `flush_req_o[0]` high at cycle 1.
- Ack sampled at cycle t → `flush_req_o[idx]` low and `flush_req_o[idx+1]` high at cycle t+1.
- Minimum latency (immediate acks, always idle) is done at cycle `NUM_DOMAINS`+`DRAIN_CYCLES`+`RST_CYCLES`+1. With the defaults this is cycle 37.
- `rst_domain_no` is low for exactly `RST_CYCLES` cycles.

## Configuration
- Macro: `UARCH_RST_TIMEOUT_EN`.
- With the macro defined:
  - In FLUSH the counter increments each cycle without an ack.
  - At counter = `TIMEOUT_CYCLES`-1 with no ack, the sequencer advances exactly as if an ack had arrived, and sets `timeout_o`.
  - An ack in that same cycle takes priority, and `timeout_o` stays unchanged.
- Without the macro:
  - FLUSH waits indefinitely for the ack.
  - `timeout_o` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Defaults, acks in the first req cycle, `idle_i`=all 1, start at cycle 0 → req one-hot 0001, 0010, 0100, 1000 at cycles 1–4; `rst_domain_no`=0 at cycles 21–36; `done_o` at 37.
- Ack for domain 2 delayed by 10 cycles → `flush_req_o`=0100 held 11 cycles; done shifts by 10; no spurious ack accepted from other bits.
- DRAIN with `idle_i[1]` dropping at drain count 9 → counter restarts; RESET begins exactly 16 cycles after `idle_i` returns to all 1.
- `start_i` held during busy, plus a restart in the `done_o` cycle → mid-sequence starts ignored; the restart raises `flush_req_o[0]` the next cycle.
- With `UARCH_RST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, domain 1 never acks → `flush_req_o[1]` high for 8 cycles, then domain 2 requested and `timeout_o`=1 until the next start. Ack arriving on the 8th cycle → `timeout_o` stays 0.
- `rst_ni` asserted during RESET → `rst_domain_no`=all 1 and `busy_o`=0 asynchronously; after release, a new start performs a full sequence.
